// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo_sc write arbiter.
//   arb_state_t : arbiter FSM state (IDLE = searching, LOCK = packet in flight)
//   idx_inc     : increment an index modulo n
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_t;

  // Wraps n-1 back to 0; used to advance the round-robin base past a
  // requester that just finished (or was evicted from) its packet.
  function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req  [N]     : request vector
//   base [IW]    : index that has highest priority this cycle (must be < N)
//   idx  [IW]    : first requesting index at or after base, wrapping mod N
//   any          : at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two copies back to back let a window of N bits starting at base cover
  // the wrap-around without any modulo on the request side.
  logic [2*N-1:0] dbl;
  int             sel;
  int             sum;

  assign dbl = {req, req};
  assign any = |req;

  always_comb begin
    sel = 0;
    // Scan downward so the lowest offset from base wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (dbl[int'(base) + j]) sel = j;
    end
    sum = int'(base) + sel;
    if (sum >= N) sum = sum - N;
    idx = IW'(sum);
  end

endmodule

// File: rtl/fifo_sc_wr_arb.sv
// fifo_sc_wr_arb: packet-granular round-robin arbiter for the write port of
// a single-clock FIFO. A grant is locked from the first beat of a packet
// until its last beat is accepted; a watchdog evicts a requester that stops
// presenting beats mid-packet.
//   clk, rst           : clock, synchronous active-high reset
//   req_val/lst [N]    : per-requester beat valid / last-beat flag
//   req_dat [N*W]      : per-requester beat data, requester i at [i*W +: W]
//   req_rdy [N]        : beat of requester i accepted this cycle
//   write, data_in [W] : FIFO write strobe and data
//   full               : FIFO full (combinational from the FIFO)
//   grant_id [IW]      : locked requester, valid while busy
//   busy               : grant locked
//   err                : one-cycle pulse when the watchdog evicts a requester
module fifo_sc_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int TO = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_val,
  input  logic [N*W-1:0]       req_dat,
  input  logic [N-1:0]         req_lst,
  output logic [N-1:0]         req_rdy,
  output logic                 write,
  output logic [W-1:0]         data_in,
  input  logic                 full,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = $clog2(N);
  // Counter is wide enough for TO; with the watchdog disabled it is 1 bit wide.
  localparam int             WW      = (TO > 0) ? $clog2(TO + 1) : 1;
  localparam logic [WW-1:0]  WD_LAST = (TO > 0) ? WW'(TO - 1) : '0;

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] ptr_reg,   ptr_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [WW-1:0] wdog_reg,  wdog_next;
  logic          err_reg,   err_next;

  logic [W-1:0]  dat_arr [N];
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] after_grant;
  logic          g_val;
  logic          g_lst;
  logic          accept;
  logic          stall;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req_val),
    .base (ptr_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign dat_arr[gi] = req_dat[gi*W +: W];
      assign req_rdy[gi] = busy && (grant_reg == IW'(gi)) && !full;
    end
  endgenerate

  assign busy     = (state_reg == LOCK);
  assign err      = err_reg;
  assign grant_id = grant_reg;

  assign g_val  = req_val[grant_reg];
  assign g_lst  = req_lst[grant_reg];
  assign accept = busy && g_val && !full;
  // Only source-side bubbles count toward the timeout; back-pressure does not.
  assign stall  = busy && !g_val && !full;

  assign write   = accept;
  assign data_in = busy ? dat_arr[grant_reg] : '0;

  assign after_grant = IW'(idx_inc(32'(grant_reg), 32'(N)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      wdog_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      wdog_reg  <= wdog_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    wdog_next  = wdog_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_idx;
          wdog_next  = '0;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          wdog_next = '0;
          if (g_lst) begin
            ptr_next   = after_grant;
            state_next = IDLE;
          end
        end else if (stall) begin
          if ((TO > 0) && (wdog_reg == WD_LAST)) begin
            // Evict the stalled requester; beats already written stay.
            err_next   = 1'b1;
            ptr_next   = after_grant;
            wdog_next  = '0;
            state_next = IDLE;
          end else if (wdog_reg != '1) begin
            wdog_next = wdog_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_sc_wr_arb.sv
// tb_fifo_sc_wr_arb: directed self-checking bench for fifo_sc_wr_arb
// (N=4, W=16, TO=8). Inputs change 1 time unit after the rising edge and
// outputs are checked 3 time units after it.
module tb_fifo_sc_wr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_val;
  logic [63:0] req_dat;
  logic [3:0]  req_lst;
  logic [3:0]  req_rdy;
  logic        write;
  logic [15:0] data_in;
  logic        full;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  int n_pass;
  int n_total;
  int n_fail;

  fifo_sc_wr_arb #(.N(4), .W(16), .TO(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_dat  (req_dat),
    .req_lst  (req_lst),
    .req_rdy  (req_rdy),
    .write    (write),
    .data_in  (data_in),
    .full     (full),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dat(input int i, input logic [15:0] d);
    req_dat[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_val = '0; req_lst = '0; req_dat = '0; full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int          beat [4];
  int          pkt  [4];
  logic [3:0]  acc;
  logic [15:0] exp2 [10];
  int          k;

  task automatic refresh_sources();
    for (int i = 0; i < 4; i++) begin
      set_dat(i, 16'((i << 8) | (pkt[i] << 4) | beat[i]));
      req_lst[i] = (beat[i] == 1);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    rst = 1'b1; req_val = '0; req_lst = '0; req_dat = '0; full = 1'b0;

    // ---- reset state
    tick(); tick(); #2;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_write", write, 0);
    chk("rst_rdy", req_rdy, 0);
    chk("rst_data", data_in, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ptr", dut.ptr_reg, 0);

    // ---- single requester 2, 3-beat packet
    tick(); rst = 1'b0; req_val = 4'b0100; set_dat(2, 16'h00A1); #2;
    chk("t1_idle_write", write, 0);
    chk("t1_idle_rdy", req_rdy, 0);
    tick(); #2;
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_w1", write, 1);
    chk("t1_d1", data_in, 16'h00A1);
    chk("t1_rdy", req_rdy, 4'b0100);
    tick(); set_dat(2, 16'h00A2); #2;
    chk("t1_w2", write, 1);
    chk("t1_d2", data_in, 16'h00A2);
    tick(); set_dat(2, 16'h00A3); req_lst = 4'b0100; #2;
    chk("t1_w3", write, 1);
    chk("t1_d3", data_in, 16'h00A3);
    tick(); req_val = '0; req_lst = '0; #2;
    chk("t1_busy_end", busy, 0);
    chk("t1_write_end", write, 0);
    chk("t1_ptr", dut.ptr_reg, 3);

    // ---- all four requesting continuously, 2-beat packets
    exp2 = '{16'h0000, 16'h0001, 16'h0100, 16'h0101, 16'h0200,
             16'h0201, 16'h0300, 16'h0301, 16'h0010, 16'h0011};
    do_reset();
    for (int i = 0; i < 4; i++) begin beat[i] = 0; pkt[i] = 0; end
    req_val = 4'hF;
    refresh_sources();
    k = 0;
    for (int c = 0; c < 15; c++) begin
      #2;
      chk("t2_write", write, (c % 3) != 0);
      if ((c % 3) != 0) begin
        chk("t2_data", data_in, exp2[k]);
        k++;
      end
      acc = req_val & req_rdy;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          beat[i]++;
          if (beat[i] == 2) begin beat[i] = 0; pkt[i]++; end
        end
      end
      refresh_sources();
    end
    req_val = '0; req_lst = '0; #2;
    chk("t2_busy_end", busy, 0);
    chk("t2_ptr", dut.ptr_reg, 1);

    // ---- full for 5 cycles during beat 2 of a 4-beat packet
    do_reset();
    req_val = 4'b0010; set_dat(1, 16'h00B1); #2;
    chk("t3_idle_write", write, 0);
    tick(); #2;
    chk("t3_w1", write, 1);
    chk("t3_d1", data_in, 16'h00B1);
    for (int c = 0; c < 5; c++) begin
      tick(); set_dat(1, 16'h00B2); full = 1'b1; #2;
      chk("t3_full_write", write, 0);
      chk("t3_full_rdy", req_rdy, 0);
      chk("t3_full_err", err, 0);
      chk("t3_full_busy", busy, 1);
    end
    tick(); full = 1'b0; #2;
    chk("t3_w2", write, 1);
    chk("t3_d2", data_in, 16'h00B2);
    chk("t3_rdy2", req_rdy, 4'b0010);
    tick(); set_dat(1, 16'h00B3); #2;
    chk("t3_d3", data_in, 16'h00B3);
    tick(); set_dat(1, 16'h00B4); req_lst = 4'b0010; #2;
    chk("t3_w4", write, 1);
    chk("t3_d4", data_in, 16'h00B4);
    tick(); req_val = '0; req_lst = '0; #2;
    chk("t3_busy_end", busy, 0);
    chk("t3_err_end", err, 0);

    // ---- watchdog (TO=8): requester 0 stalls after beat 1, requester 2 waits
    do_reset();
    req_val = 4'b0101; set_dat(0, 16'h00C1); set_dat(2, 16'h00D1); req_lst = 4'b0100; #2;
    chk("t4_idle_write", write, 0);
    tick(); #2;
    chk("t4_grant0", grant_id, 0);
    chk("t4_w1", write, 1);
    chk("t4_d1", data_in, 16'h00C1);
    for (int c = 0; c < 8; c++) begin
      tick(); req_val[0] = 1'b0; #2;
      chk("t4_stall_write", write, 0);
      chk("t4_stall_err", err, 0);
      chk("t4_stall_busy", busy, 1);
      chk("t4_stall_rdy", req_rdy, 4'b0001);
    end
    tick(); #2;
    chk("t4_err", err, 1);
    chk("t4_busy_idle", busy, 0);
    chk("t4_write_idle", write, 0);
    chk("t4_ptr", dut.ptr_reg, 1);
    tick(); #2;
    chk("t4_err_clear", err, 0);
    chk("t4_grant2", grant_id, 2);
    chk("t4_busy2", busy, 1);
    chk("t4_w_d1", write, 1);
    chk("t4_data_d1", data_in, 16'h00D1);
    tick(); req_val = '0; req_lst = '0; #2;
    chk("t4_single_end", busy, 0);
    chk("t4_ptr3", dut.ptr_reg, 3);

    // ---- reset during beat 2 of a packet (ptr=3 entering)
    tick(); req_val = 4'b1010; set_dat(3, 16'h00F1); set_dat(1, 16'h0061); #2;
    chk("t5_idle", busy, 0);
    tick(); #2;
    chk("t5_grant3", grant_id, 3);
    chk("t5_d1", data_in, 16'h00F1);
    tick(); set_dat(3, 16'h00F2); rst = 1'b1; #2;
    chk("t5_d2", data_in, 16'h00F2);
    tick(); rst = 1'b0; #2;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_write", write, 0);
    chk("t5_rst_ptr", dut.ptr_reg, 0);
    chk("t5_rst_grant", grant_id, 0);
    tick(); #2;
    chk("t5_grant1", grant_id, 1);
    chk("t5_busy1", busy, 1);
    chk("t5_data1", data_in, 16'h0061);

    // ---- requesters 0 and 3 together with ptr=1
    do_reset();
    req_val = 4'b0001; req_lst = 4'b0001; set_dat(0, 16'h0070); #2;
    tick(); #2;
    chk("t6_pre_write", write, 1);
    chk("t6_pre_grant", grant_id, 0);
    tick(); req_val = '0; req_lst = '0; #2;
    chk("t6_pre_ptr", dut.ptr_reg, 1);
    tick(); req_val = 4'b1001; req_lst = 4'b1001;
    set_dat(0, 16'h00E0); set_dat(3, 16'h00E3); #2;
    chk("t6_idle", busy, 0);
    tick(); #2;
    chk("t6_grant3", grant_id, 3);
    chk("t6_w3", write, 1);
    chk("t6_d3", data_in, 16'h00E3);
    tick(); req_val = 4'b0001; req_lst = 4'b0001; #2;
    chk("t6_gap", busy, 0);
    chk("t6_ptr0", dut.ptr_reg, 0);
    tick(); #2;
    chk("t6_grant0", grant_id, 0);
    chk("t6_w0", write, 1);
    chk("t6_d0", data_in, 16'h00E0);
    tick(); req_val = '0; req_lst = '0; #2;
    chk("t6_end", busy, 0);
    chk("t6_ptr1", dut.ptr_reg, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
